icache_store: RTL and testbench

ICACHE_STORE -- requirements
Module: icache_store

---
 rtl/icache_store.sv | 152 +++++++++++++++
 tb/tb_icache_store.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/icache_store.sv
// Two-way, 128-set instruction cache storage with combinational lookup and a
// small write FSM that installs a full 256-bit line chosen by valid/LRU.
//
// state  | meaning
// IDLE   | waiting for wen; latches waddr/wdata when it rises
// VICTIM | picks the way to replace in the latched set
// WRITE  | next edge commits tag, line and valid into the victim way
// DONE   | w_end high; held until wen drops
module icache_store (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr,
  input  logic         wen,
  input  logic [31:0]  waddr,
  input  logic [255:0] wdata,
  output logic         valid1,
  output logic         valid2,
  output logic [19:0]  tag1,
  output logic [19:0]  tag2,
  output logic [31:0]  data1,
  output logic [31:0]  data2,
  output logic         w_end
);

  typedef enum logic [1:0] {IDLE, VICTIM, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [19:0]   wtag_q, wtag_d;
  logic [6:0]    wset_q, wset_d;
  logic [255:0]  wline_q, wline_d;
  logic          victim_q, victim_d;
  logic          w_end_q, w_end_d;

  logic [127:0]  w0_valid_q, w1_valid_q, lru_q;
  logic [19:0]   w0_tag_q  [128];
  logic [19:0]   w1_tag_q  [128];
  logic [255:0]  w0_line_q [128];
  logic [255:0]  w1_line_q [128];

  logic [6:0]    rd_set;
  logic [2:0]    rd_word;
  logic          hit0, hit1;
  logic          arr_we;
  logic          lru_we;
  logic [6:0]    lru_idx;
  logic          lru_val;
  logic          unused_bits;

  assign unused_bits = ^{waddr[4:0], addr[1:0]};

  assign rd_set  = addr[11:5];
  assign rd_word = addr[4:2];

  assign valid1 = w0_valid_q[rd_set];
  assign valid2 = w1_valid_q[rd_set];
  assign tag1   = w0_tag_q[rd_set];
  assign tag2   = w1_tag_q[rd_set];
  assign data1  = w0_line_q[rd_set][{rd_word, 5'd0} +: 32];
  assign data2  = w1_line_q[rd_set][{rd_word, 5'd0} +: 32];
  assign w_end  = w_end_q;

  assign hit0 = valid1 && (tag1 == addr[31:12]);
  assign hit1 = valid2 && (tag2 == addr[31:12]);

  always_comb begin
    state_d  = state_q;
    wtag_d   = wtag_q;
    wset_d   = wset_q;
    wline_d  = wline_q;
    victim_d = victim_q;
    arr_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wen) begin
          state_d = VICTIM;
          wtag_d  = waddr[31:12];
          wset_d  = waddr[11:5];
          wline_d = wdata;
        end
      end
      VICTIM: begin
        state_d = WRITE;
        if (!w0_valid_q[wset_q])      victim_d = 1'b0;
        else if (!w1_valid_q[wset_q]) victim_d = 1'b1;
        else                          victim_d = lru_q[wset_q];
      end
      WRITE: begin
        state_d = DONE;
        arr_we  = 1'b1;
      end
      DONE: begin
        if (!wen) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    w_end_d = (state_d == DONE);
  end

  // Line install owns the LRU bit on its edge; lookup hits only update it otherwise.
  always_comb begin
    lru_we  = 1'b0;
    lru_idx = rd_set;
    lru_val = 1'b0;
    if (arr_we) begin
      lru_we  = 1'b1;
      lru_idx = wset_q;
      lru_val = ~victim_q;
    end else if (hit0 || hit1) begin
      lru_we  = 1'b1;
      lru_idx = rd_set;
      lru_val = ~hit1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wtag_q     <= '0;
      wset_q     <= '0;
      wline_q    <= '0;
      victim_q   <= 1'b0;
      w_end_q    <= 1'b0;
      w0_valid_q <= '0;
      w1_valid_q <= '0;
      lru_q      <= '0;
      w0_tag_q   <= '{default: '0};
      w1_tag_q   <= '{default: '0};
      w0_line_q  <= '{default: '0};
      w1_line_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      wtag_q   <= wtag_d;
      wset_q   <= wset_d;
      wline_q  <= wline_d;
      victim_q <= victim_d;
      w_end_q  <= w_end_d;
      if (arr_we) begin
        if (victim_q) begin
          w1_valid_q[wset_q] <= 1'b1;
          w1_tag_q[wset_q]   <= wtag_q;
          w1_line_q[wset_q]  <= wline_q;
        end else begin
          w0_valid_q[wset_q] <= 1'b1;
          w0_tag_q[wset_q]   <= wtag_q;
          w0_line_q[wset_q]  <= wline_q;
        end
      end
      if (lru_we) lru_q[lru_idx] <= lru_val;
    end
  end

endmodule

// File: tb/tb_icache_store.sv
// Directed bench for icache_store: fills, LRU replacement, held wen,
// write/hit LRU collision and reset in the middle of a line write.
module tb_icache_store;

  localparam logic [31:0] PARK = 32'h000F_FFE0;  // set 127, never written

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr;
  logic         wen;
  logic [31:0]  waddr;
  logic [255:0] wdata;
  logic         valid1, valid2;
  logic [19:0]  tag1, tag2;
  logic [31:0]  data1, data2;
  logic         w_end;

  int n_checks = 0;
  int n_pass   = 0;

  icache_store dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wen    (wen),
    .waddr  (waddr),
    .wdata  (wdata),
    .valid1 (valid1),
    .valid2 (valid2),
    .tag1   (tag1),
    .tag2   (tag2),
    .data1  (data1),
    .data2  (data2),
    .w_end  (w_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic probe(input logic [31:0] a);
    addr = a;
    #1;
  endtask

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
    return l;
  endfunction

  task automatic do_write(input logic [31:0] wa, input logic [255:0] wd, input string tag);
    wen = 1'b1; waddr = wa; wdata = wd;
    tick();
    check({tag, "_wend_n"}, {31'd0, w_end}, 32'd0);
    tick();
    check({tag, "_wend_n1"}, {31'd0, w_end}, 32'd0);
    tick();
    check({tag, "_wend_n2"}, {31'd0, w_end}, 32'd1);
    wen = 1'b0;
    tick();
    check({tag, "_wend_idle"}, {31'd0, w_end}, 32'd0);
  endtask

  logic [255:0] line1;

  initial begin
    rst = 1'b0; wen = 1'b0; addr = PARK; waddr = '0; wdata = '0;
    tick(); tick();
    check("rst_wend", {31'd0, w_end}, 32'd0);
    probe(32'h0000_1020);
    check("rst_valid1", {31'd0, valid1}, 32'd0);
    check("rst_valid2", {31'd0, valid2}, 32'd0);
    check("rst_tag1", {12'd0, tag1}, 32'd0);
    check("rst_tag2", {12'd0, tag2}, 32'd0);
    check("rst_data1", data1, 32'd0);
    check("rst_data2", data2, 32'd0);
    addr = PARK;
    rst = 1'b1;
    tick();

    // cold write into set 1, way 0
    line1 = make_line(32'h1111_0000);
    line1[127:96] = 32'hDEAD_BEEF;
    do_write(32'h0000_1020, line1, "cold");
    probe(32'h0000_102C);
    check("cold_valid1", {31'd0, valid1}, 32'd1);
    check("cold_tag1", {12'd0, tag1}, 32'h0000_0001);
    check("cold_data1", data1, 32'hDEAD_BEEF);
    check("cold_valid2", {31'd0, valid2}, 32'd0);
    addr = PARK;

    // second fill goes to way 1
    do_write(32'h0000_2020, make_line(32'h2222_0000), "fill2");
    probe(32'h0000_2024);
    check("fill2_valid2", {31'd0, valid2}, 32'd1);
    check("fill2_tag2", {12'd0, tag2}, 32'h0000_0002);
    check("fill2_data2", data2, 32'h2222_0001);
    check("fill2_tag1", {12'd0, tag1}, 32'h0000_0001);
    check("fill2_data1", data1, 32'h1111_0001);
    addr = PARK;

    // hit way 0, then a write with held wen and input changes after IDLE
    addr = 32'h0000_1020;
    tick();
    addr = PARK;
    wen = 1'b1; waddr = 32'h0000_3020; wdata = make_line(32'h3333_0000);
    tick();
    check("lru_wend_n", {31'd0, w_end}, 32'd0);
    waddr = 32'h0000_5020; wdata = make_line(32'h5555_0000);
    tick();
    check("lru_wend_n1", {31'd0, w_end}, 32'd0);
    tick();
    check("lru_wend_n2", {31'd0, w_end}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("held_wend_%0d", i), {31'd0, w_end}, 32'd1);
    end
    wen = 1'b0;
    tick();
    check("held_wend_drop", {31'd0, w_end}, 32'd0);
    probe(32'h0000_3038);
    check("lru_tag2", {12'd0, tag2}, 32'h0000_0003);
    check("lru_data2", data2, 32'h3333_0006);
    check("lru_tag1", {12'd0, tag1}, 32'h0000_0001);
    check("lru_valid1", {31'd0, valid1}, 32'd1);
    addr = PARK;

    // hit on way 1 of set 1 on the same edge the write lands in way 0
    wen = 1'b1; waddr = 32'h0000_4020; wdata = make_line(32'h4444_0000);
    tick();
    tick();
    addr = 32'h0000_3020;
    tick();
    addr = PARK;
    check("coll_wend", {31'd0, w_end}, 32'd1);
    wen = 1'b0;
    tick();
    probe(32'h0000_4020);
    check("coll_tag1", {12'd0, tag1}, 32'h0000_0004);
    check("coll_data1", data1, 32'h4444_0000);
    check("coll_tag2", {12'd0, tag2}, 32'h0000_0003);
    addr = PARK;
    do_write(32'h0000_6020, make_line(32'h6666_0000), "after_coll");
    probe(32'h0000_6020);
    check("coll_next_tag2", {12'd0, tag2}, 32'h0000_0006);
    check("coll_next_tag1", {12'd0, tag1}, 32'h0000_0004);
    addr = PARK;

    // reset while the write sits in VICTIM
    wen = 1'b1; waddr = 32'h0000_7020; wdata = make_line(32'h7070_0000);
    tick();
    rst = 1'b0;
    tick();
    check("abort_wend_rst", {31'd0, w_end}, 32'd0);
    rst = 1'b1; wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_wend_%0d", i), {31'd0, w_end}, 32'd0);
    end
    probe(32'h0000_1020);
    check("abort_valid1", {31'd0, valid1}, 32'd0);
    check("abort_valid2", {31'd0, valid2}, 32'd0);
    check("abort_tag1", {12'd0, tag1}, 32'd0);
    check("abort_data2", data2, 32'd0);
    addr = PARK;

    // FSM back in IDLE: a fresh write to set 2 completes with normal latency
    do_write(32'hABCD_E040, make_line(32'h7777_0000), "post_rst");
    probe(32'hABCD_E05C);
    check("post_valid1", {31'd0, valid1}, 32'd1);
    check("post_tag1", {12'd0, tag1}, 32'h000A_BCDE);
    check("post_data1", data1, 32'h7777_0007);
    check("post_valid2", {31'd0, valid2}, 32'd0);
    probe(32'hABCD_E020);
    check("post_set1_valid1", {31'd0, valid1}, 32'd0);
    addr = PARK;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
